// File: rtl/sort_memory_slave_if.sv
// Memory-side bus of the sort engine: AR/R read channels and AW/W write
// channels. The sort engine connects to the master modport and the array
// memory connects to the slave modport.
interface sort_memory_slave_if #(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32,
   parameter int RESP_WDTH = 1
);
   logic                 ar_valid;
   logic                 ar_ready;
   logic [ADDR_WDTH-1:0] ar_address;
   logic                 r_valid;
   logic                 r_ready;
   logic [RESP_WDTH-1:0] r_resp;
   logic [DATA_WDTH-1:0] r_data;
   logic                 aw_valid;
   logic                 aw_ready;
   logic [ADDR_WDTH-1:0] aw_address;
   logic                 w_valid;
   logic                 w_ready;
   logic [DATA_WDTH-1:0] w_data;

   modport master (
      output ar_valid, ar_address, r_ready, aw_valid, aw_address, w_valid, w_data,
      input  ar_ready, r_valid, r_resp, r_data, aw_ready, w_ready
   );

   modport slave (
      input  ar_valid, ar_address, r_ready, aw_valid, aw_address, w_valid, w_data,
      output ar_ready, r_valid, r_resp, r_data, aw_ready, w_ready
   );
endinterface

// File: rtl/sort_memory_slave.sv
// Word-addressed array memory serving the sort engine's AR/R and AW/W
// channels, with a backdoor port for loading the unsorted array and
// inspecting the result. One read is outstanding at a time; a write commits
// once both its address and its data have been buffered.
// Optional build macro SORT_MEM_ADDR_CHECK_EN: out-of-range reads answer
// with r_resp=1 and a sticky addr_err output flags any out-of-range access.
module sort_memory_slave #(
   parameter int ADDR_WDTH  = 4,
   parameter int DATA_WDTH  = 32,
   parameter int RESP_WDTH  = 1,
   parameter int DEPTH      = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sort_memory_slave_if.slave   bus,
   input  logic                 bd_we,
   input  logic [ADDR_WDTH-1:0] bd_addr,
   input  logic [DATA_WDTH-1:0] bd_wdata,
   output logic [DATA_WDTH-1:0] bd_rdata
`ifdef SORT_MEM_ADDR_CHECK_EN
   ,
   output logic                 addr_err
`endif
);

   localparam logic [ADDR_WDTH:0] DEPTH_L = (ADDR_WDTH+1)'(DEPTH);
   localparam logic [3:0]         LAT_M1  = 4'(RD_LATENCY - 1);

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } rd_state_t;

   // Addresses at or beyond DEPTH have no backing word.
   function automatic logic in_range(input logic [ADDR_WDTH-1:0] addr);
      return ({1'b0, addr} < DEPTH_L);
   endfunction

   logic [DATA_WDTH-1:0] mem_r [DEPTH];

   rd_state_t            state_r;
   rd_state_t            next_state_s;
   logic [3:0]           cnt_r;
   logic [ADDR_WDTH-1:0] rd_addr_r;
   logic [DATA_WDTH-1:0] r_data_r;
   logic [RESP_WDTH-1:0] r_resp_r;
   logic                 resp_entry_s;
   logic                 ar_ready_s;
   logic                 r_valid_s;
   logic                 ar_hs_s;
   logic                 r_hs_s;
   logic [ADDR_WDTH-1:0] rd_sel_s;
   logic [DATA_WDTH-1:0] rd_word_s;
   logic                 rd_err_s;

   logic                 aw_full_r;
   logic [ADDR_WDTH-1:0] aw_addr_r;
   logic                 w_full_r;
   logic [DATA_WDTH-1:0] w_data_r;
   logic                 aw_hs_s;
   logic                 w_hs_s;
   logic                 commit_s;

   assign ar_hs_s  = bus.ar_valid && ar_ready_s;
   assign r_hs_s   = r_valid_s && bus.r_ready;
   assign aw_hs_s  = bus.aw_valid && !aw_full_r;
   assign w_hs_s   = bus.w_valid && !w_full_r;
   assign commit_s = aw_full_r && w_full_r;

   assign bus.ar_ready = ar_ready_s;
   assign bus.r_valid  = r_valid_s;
   assign bus.r_data   = r_data_r;
   assign bus.r_resp   = r_resp_r;
   assign bus.aw_ready = !aw_full_r;
   assign bus.w_ready  = !w_full_r;

`ifdef SORT_MEM_ADDR_CHECK_EN
   assign rd_err_s = !in_range(rd_sel_s);
`else
   assign rd_err_s = 1'b0;
`endif

   // Read FSM state register and latency counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= R_IDLE;
         cnt_r     <= 4'd0;
         rd_addr_r <= {ADDR_WDTH{1'b0}};
      end else begin
         state_r <= next_state_s;
         if (ar_hs_s) begin
            cnt_r     <= LAT_M1;
            rd_addr_r <= bus.ar_address;
         end else if (state_r == R_WAIT) begin
            cnt_r <= cnt_r - 4'd1;
         end
      end
   end

   // Read FSM next state; flags the edge on which the response is captured.
   always_comb begin
      next_state_s = state_r;
      resp_entry_s = 1'b0;
      case (state_r)
         R_IDLE: begin
            if (ar_hs_s) begin
               if (LAT_M1 == 4'd0) begin
                  next_state_s = R_RESP;
                  resp_entry_s = 1'b1;
               end else begin
                  next_state_s = R_WAIT;
               end
            end else begin
               next_state_s = R_IDLE;
            end
         end
         R_WAIT: begin
            if (cnt_r <= 4'd1) begin
               next_state_s = R_RESP;
               resp_entry_s = 1'b1;
            end else begin
               next_state_s = R_WAIT;
            end
         end
         R_RESP: begin
            if (r_hs_s) begin
               next_state_s = R_IDLE;
            end else begin
               next_state_s = R_RESP;
            end
         end
         default: begin
            next_state_s = R_IDLE;
         end
      endcase
   end

   // Read FSM outputs decoded from the registered state.
   always_comb begin
      ar_ready_s = 1'b0;
      r_valid_s  = 1'b0;
      case (state_r)
         R_IDLE:  ar_ready_s = 1'b1;
         R_WAIT:  ar_ready_s = 1'b0;
         R_RESP:  r_valid_s  = 1'b1;
         default: ar_ready_s = 1'b0;
      endcase
   end

   // Array lookups: the read side uses the live address when the response is
   // captured on the handshake edge itself (latency 1), else the latched one.
   always_comb begin
      if (state_r == R_IDLE) begin
         rd_sel_s = bus.ar_address;
      end else begin
         rd_sel_s = rd_addr_r;
      end
      if (in_range(rd_sel_s)) begin
         rd_word_s = mem_r[rd_sel_s];
      end else begin
         rd_word_s = {DATA_WDTH{1'b0}};
      end
      if (in_range(bd_addr)) begin
         bd_rdata = mem_r[bd_addr];
      end else begin
         bd_rdata = {DATA_WDTH{1'b0}};
      end
   end

   // Response registers: captured on R_RESP entry, cleared once consumed so
   // r_resp never shows stale status outside a valid beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_r <= {DATA_WDTH{1'b0}};
         r_resp_r <= {RESP_WDTH{1'b0}};
      end else if (resp_entry_s) begin
         r_data_r <= rd_word_s;
         r_resp_r <= RESP_WDTH'(rd_err_s);
      end else if (r_hs_s) begin
         r_data_r <= {DATA_WDTH{1'b0}};
         r_resp_r <= {RESP_WDTH{1'b0}};
      end
   end

   // Single-entry AW and W buffers, both released by the commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_full_r <= 1'b0;
         aw_addr_r <= {ADDR_WDTH{1'b0}};
         w_full_r  <= 1'b0;
         w_data_r  <= {DATA_WDTH{1'b0}};
      end else begin
         if (aw_hs_s) begin
            aw_full_r <= 1'b1;
            aw_addr_r <= bus.aw_address;
         end else if (commit_s) begin
            aw_full_r <= 1'b0;
         end
         if (w_hs_s) begin
            w_full_r <= 1'b1;
            w_data_r <= bus.w_data;
         end else if (commit_s) begin
            w_full_r <= 1'b0;
         end
      end
   end

   // Array storage: backdoor beats a same-address channel commit; addresses
   // beyond DEPTH match no word and are silently dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_WDTH{1'b0}};
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (bd_we && (bd_addr == ADDR_WDTH'(i))) begin
               mem_r[i] <= bd_wdata;
            end else if (commit_s && (aw_addr_r == ADDR_WDTH'(i))) begin
               mem_r[i] <= w_data_r;
            end
         end
      end
   end

`ifdef SORT_MEM_ADDR_CHECK_EN
   logic addr_err_r;

   // Sticky out-of-range flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err_r <= 1'b0;
      end else if ((ar_hs_s && !in_range(bus.ar_address)) ||
                   (aw_hs_s && !in_range(bus.aw_address)) ||
                   (bd_we   && !in_range(bd_addr))) begin
         addr_err_r <= 1'b1;
      end
   end

   assign addr_err = addr_err_r;
`endif

endmodule
